// File: rtl/icache_pkg.sv
// icache_pkg: shared types for the instruction-cache fill controller.
//   bus_cmd_e     - instruction-memory bus command (BUS_NONE / BUS_LOAD)
//   mshr_entry_t  - one outstanding-load entry {valid, mem_tag, addr[31:3]}
//   walk_state_e  - prefetch walk FSM states
//   BLK_OFS       - byte-offset bits inside a 64-bit block
//   blk()         - block-align an address
package icache_pkg;

    localparam int BLK_OFS = 3;

    typedef enum logic [1:0] {
        BUS_NONE = 2'd0,
        BUS_LOAD = 2'd1
    } bus_cmd_e;

    typedef struct packed {
        logic        valid;
        logic [3:0]  mem_tag;
        logic [28:0] addr;
    } mshr_entry_t;

    typedef enum logic {
        WALK_IDLE,
        WALK_ACTIVE
    } walk_state_e;

    function automatic logic [31:0] blk(input logic [31:0] a);
        return {a[31:BLK_OFS], {BLK_OFS{1'b0}}};
    endfunction

endpackage

// File: rtl/icache_mshr_table.sv
// icache_mshr_table: outstanding-load table with allocate, free-by-tag and
// address-match CAM.
//   alloc_en/alloc_tag/alloc_addr : write lowest free entry at the edge
//   done_tag                      : nonzero tag frees the matching entry
//   demand_addr/walk_addr         : CAM lookups -> demand_hit/walk_hit
//   free_avail                    : at least one entry free this cycle
//   done_hit/done_addr            : completing tag matched, its block address
//   any_valid                     : any entry outstanding
module icache_mshr_table
    import icache_pkg::*;
#(
    parameter int NUM_MSHR = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        alloc_en,
    input  logic [3:0]  alloc_tag,
    input  logic [28:0] alloc_addr,
    input  logic [3:0]  done_tag,
    input  logic [28:0] demand_addr,
    input  logic [28:0] walk_addr,
    output logic        free_avail,
    output logic        demand_hit,
    output logic        walk_hit,
    output logic        done_hit,
    output logic [28:0] done_addr,
    output logic        any_valid
);
    localparam int IDX_W = $clog2(NUM_MSHR);

    mshr_entry_t [NUM_MSHR-1:0] ent;
    logic [IDX_W-1:0]           free_idx;
    logic [NUM_MSHR-1:0]        done_match;

    // Descending scan so the lowest index wins for both free slot and match.
    // An entry completing this cycle is still valid here, so it still counts
    // as pending and is not offered as free until the next cycle.
    always_comb begin
        free_avail = 1'b0;
        free_idx   = '0;
        demand_hit = 1'b0;
        walk_hit   = 1'b0;
        done_hit   = 1'b0;
        done_addr  = '0;
        any_valid  = 1'b0;
        done_match = '0;
        for (int i = NUM_MSHR - 1; i >= 0; i--) begin
            if (!ent[i].valid) begin
                free_avail = 1'b1;
                free_idx   = IDX_W'(i);
            end else begin
                any_valid = 1'b1;
                if (ent[i].addr == demand_addr) demand_hit = 1'b1;
                if (ent[i].addr == walk_addr)   walk_hit   = 1'b1;
                if (done_tag != 4'd0 && ent[i].mem_tag == done_tag) begin
                    done_match[i] = 1'b1;
                    done_hit      = 1'b1;
                    done_addr     = ent[i].addr;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ent <= '0;
        end else begin
            for (int i = 0; i < NUM_MSHR; i++) begin
                if (done_match[i]) begin
                    ent[i].valid <= 1'b0;
                end else if (alloc_en && free_idx == IDX_W'(i)) begin
                    ent[i] <= '{valid: 1'b1, mem_tag: alloc_tag, addr: alloc_addr};
                end
            end
        end
    end

endmodule

// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl: icache demand-miss fill and prefetch-walk controller.
// Optional feature macro: ICACHE_PREFETCH_EN (prefetch walk + cache probe).
//   miss_valid/miss_pc            : demand miss from fetch
//   prefetch_pc_check             : block probed in icache (walk candidate)
//   prefetch_pc_is_in_cache       : same-cycle probe hit
//   proc2Imem_command/addr        : block load request (combinational)
//   Imem2proc_response            : granted tag, 0 = rejected
//   Imem2proc_tag/data            : completing tag and block data
//   icache_write_enable/addr/data : one-cycle fill, cycle after tag match
//   busy                          : loads outstanding or walk active
module icache_fill_ctrl
    import icache_pkg::*;
#(
    parameter int NUM_MSHR       = 4,
    parameter int PREFETCH_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        miss_valid,
    input  logic [31:0] miss_pc,
    output logic [31:0] prefetch_pc_check,
    input  logic        prefetch_pc_is_in_cache,
    output logic [1:0]  proc2Imem_command,
    output logic [31:0] proc2Imem_addr,
    input  logic [3:0]  Imem2proc_response,
    input  logic [3:0]  Imem2proc_tag,
    input  logic [63:0] Imem2proc_data,
    output logic        icache_write_enable,
    output logic [31:0] icache_write_addr,
    output logic [63:0] icache_write_data,
    output logic        busy
);
    localparam logic [31:0] LAST_BLK = 32'hFFFF_FFF8;

    logic [31:0] demand_blk;
    logic        free_avail, demand_pend, walk_pend, done_hit, any_valid;
    logic [28:0] done_addr;
    logic        demand_cand, walk_cand, walk_skip, walk_active;
    logic        issue, accept;
    logic [31:0] walk_addr, cand_addr;

    assign demand_blk  = blk(miss_pc);
    assign demand_cand = miss_valid && !demand_pend;

`ifdef ICACHE_PREFETCH_EN
    localparam int CNT_W = (PREFETCH_DEPTH > 1) ? $clog2(PREFETCH_DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PREFETCH_DEPTH - 1);

    walk_state_e      state_q, state_d;
    logic [31:0]      pf_addr_q, pf_addr_d;
    logic [CNT_W-1:0] pf_cnt_q, pf_cnt_d;
    logic             unused_cfg;

    assign unused_cfg        = ^{miss_pc[2:0], PREFETCH_DEPTH[0]};
    assign walk_active       = (state_q == WALK_ACTIVE);
    assign walk_addr         = pf_addr_q;
    assign walk_cand         = walk_active && !demand_cand;
    // A full table freezes the walk: no skip, so the resident/pending
    // check is repeated once space frees up.
    assign walk_skip         = walk_cand && free_avail && (walk_pend || prefetch_pc_is_in_cache);
    assign prefetch_pc_check = walk_cand ? pf_addr_q : 32'h0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= WALK_IDLE;
            pf_addr_q <= '0;
            pf_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            pf_addr_q <= pf_addr_d;
            pf_cnt_q  <= pf_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pf_addr_d = pf_addr_q;
        pf_cnt_d  = pf_cnt_q;
        if (accept && demand_cand) begin
            // Restart from the new miss; a miss in the top block has nothing ahead.
            pf_addr_d = demand_blk + 32'd8;
            pf_cnt_d  = '0;
            state_d   = (demand_blk == LAST_BLK) ? WALK_IDLE : WALK_ACTIVE;
        end else if (walk_skip || (accept && walk_cand)) begin
            if (pf_cnt_q == LAST_CNT || pf_addr_q == LAST_BLK) begin
                state_d = WALK_IDLE;
            end else begin
                pf_addr_d = pf_addr_q + 32'd8;
                pf_cnt_d  = pf_cnt_q + CNT_W'(1);
            end
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg        = ^{miss_pc[2:0], prefetch_pc_is_in_cache, walk_pend, PREFETCH_DEPTH[0]};
    assign walk_active       = 1'b0;
    assign walk_addr         = 32'h0;
    assign walk_cand         = 1'b0;
    assign walk_skip         = 1'b0;
    assign prefetch_pc_check = 32'h0;
`endif

    // Gated by reset_n so the bus sees BUS_NONE while reset is held.
    assign issue     = reset_n && free_avail && (demand_cand || (walk_cand && !walk_skip));
    assign cand_addr = demand_cand ? demand_blk : walk_addr;
    assign accept    = issue && (Imem2proc_response != 4'd0);

    assign proc2Imem_command = issue ? BUS_LOAD : BUS_NONE;
    assign proc2Imem_addr    = issue ? cand_addr : 32'h0;
    assign busy              = any_valid || walk_active;

    icache_mshr_table #(.NUM_MSHR(NUM_MSHR)) u_mshr (
        .clock       (clock),
        .reset_n     (reset_n),
        .alloc_en    (accept),
        .alloc_tag   (Imem2proc_response),
        .alloc_addr  (cand_addr[31:3]),
        .done_tag    (Imem2proc_tag),
        .demand_addr (demand_blk[31:3]),
        .walk_addr   (walk_addr[31:3]),
        .free_avail  (free_avail),
        .demand_hit  (demand_pend),
        .walk_hit    (walk_pend),
        .done_hit    (done_hit),
        .done_addr   (done_addr),
        .any_valid   (any_valid)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            icache_write_enable <= 1'b0;
            icache_write_addr   <= '0;
            icache_write_data   <= '0;
        end else begin
            icache_write_enable <= done_hit;
            if (done_hit) begin
                icache_write_addr <= {done_addr, 3'b000};
                icache_write_data <= Imem2proc_data;
            end
        end
    end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
module tb_icache_fill_ctrl;
    localparam int NUM_MSHR       = 4;
    localparam int PREFETCH_DEPTH = 4;
`ifdef ICACHE_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        miss_valid = 1'b0;
    logic [31:0] miss_pc = '0;
    logic [31:0] prefetch_pc_check;
    logic        prefetch_pc_is_in_cache;
    logic [1:0]  proc2Imem_command;
    logic [31:0] proc2Imem_addr;
    logic [3:0]  Imem2proc_response = '0;
    logic [3:0]  Imem2proc_tag = '0;
    logic [63:0] Imem2proc_data = '0;
    logic        icache_write_enable;
    logic [31:0] icache_write_addr;
    logic [63:0] icache_write_data;
    logic        busy;

    always #5 clock = ~clock;

    icache_fill_ctrl #(.NUM_MSHR(NUM_MSHR), .PREFETCH_DEPTH(PREFETCH_DEPTH)) dut (
        .clock                   (clock),
        .reset_n                 (reset_n),
        .miss_valid              (miss_valid),
        .miss_pc                 (miss_pc),
        .prefetch_pc_check       (prefetch_pc_check),
        .prefetch_pc_is_in_cache (prefetch_pc_is_in_cache),
        .proc2Imem_command       (proc2Imem_command),
        .proc2Imem_addr          (proc2Imem_addr),
        .Imem2proc_response      (Imem2proc_response),
        .Imem2proc_tag           (Imem2proc_tag),
        .Imem2proc_data          (Imem2proc_data),
        .icache_write_enable     (icache_write_enable),
        .icache_write_addr       (icache_write_addr),
        .icache_write_data       (icache_write_data),
        .busy                    (busy)
    );

    // Icache residency: one directed block plus an optional pseudo-random set.
    logic [31:0] res_addr = 32'hFFFF_FFFF;
    logic        rnd_res  = 1'b0;
    assign prefetch_pc_is_in_cache = (prefetch_pc_check == res_addr) ||
                                     (rnd_res && prefetch_pc_check[5:3] == 3'd5);

    int errs = 0, checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: outstanding loads keyed by tag, walk as next block + blocks left.
    bit          out_v[16];
    logic [31:0] out_addr[16];
    int          out_n;
    bit          w_act;
    logic [31:0] w_addr;
    int          w_left;
    bit          f_en;
    logic [31:0] f_addr;
    logic [63:0] f_data;

    logic [31:0] ld_log[$];
    logic [31:0] fl_addr[$];
    logic [63:0] fl_data[$];
    int          cmd_cnt;
    int          cmd_at_4000;

    function automatic logic [3:0] nf();
        for (int t = 1; t < 16; t++) if (!out_v[t]) return 4'(t);
        return 4'd0;
    endfunction

    function automatic logic [3:0] rf();
        int s = $urandom_range(1, 15);
        for (int k = 0; k < 15; k++) begin
            int t = ((s - 1 + k) % 15) + 1;
            if (!out_v[t]) return 4'(t);
        end
        return 4'd0;
    endfunction

    function automatic logic [3:0] ro();
        int s = $urandom_range(1, 15);
        for (int k = 0; k < 15; k++) begin
            int t = ((s - 1 + k) % 15) + 1;
            if (out_v[t]) return 4'(t);
        end
        return 4'd0;
    endfunction

    task automatic model_clear();
        for (int t = 0; t < 16; t++) out_v[t] = 1'b0;
        out_n = 0; w_act = 1'b0; w_addr = '0; w_left = 0; f_en = 1'b0;
    endtask

    task automatic cycle(input logic mv, input logic [31:0] pc, input logic [3:0] rsp,
                         input logic [3:0] tg, input logic [63:0] dt);
        logic [31:0] dblk, e_addr, e_chk;
        bit dem, wc, full, skip, iss, pend_d, pend_w;
        @(negedge clock);
        miss_valid = mv; miss_pc = pc; Imem2proc_response = rsp;
        Imem2proc_tag = tg; Imem2proc_data = dt;
        #1;
        dblk = pc & 32'hFFFF_FFF8;
        pend_d = 1'b0; pend_w = 1'b0;
        for (int t = 1; t < 16; t++) if (out_v[t]) begin
            if (out_addr[t] == dblk)   pend_d = 1'b1;
            if (out_addr[t] == w_addr) pend_w = 1'b1;
        end
        dem  = mv && !pend_d;
        wc   = PF && w_act && !dem;
        full = out_n >= NUM_MSHR;
        skip = wc && !full && (pend_w || w_addr == res_addr || (rnd_res && w_addr[5:3] == 3'd5));
        iss  = !full && (dem || (wc && !skip));
        e_addr = iss ? (dem ? dblk : w_addr) : 32'h0;
        e_chk  = wc ? w_addr : 32'h0;
        chk("cmd", proc2Imem_command, iss ? 64'd1 : 64'd0);
        chk("addr", proc2Imem_addr, e_addr);
        chk("probe", prefetch_pc_check, e_chk);
        chk("busy", busy, (out_n > 0 || w_act) ? 64'd1 : 64'd0);
        chk("wr_en", icache_write_enable, f_en);
        if (f_en) begin
            chk("wr_addr", icache_write_addr, f_addr);
            chk("wr_data", icache_write_data, f_data);
        end
        if (proc2Imem_command == 2'd1) cmd_cnt++;
        if (proc2Imem_command == 2'd1 && proc2Imem_addr == 32'h4000) cmd_at_4000++;
        if (proc2Imem_command == 2'd1 && rsp != 4'd0) ld_log.push_back(proc2Imem_addr);
        if (icache_write_enable) begin
            fl_addr.push_back(icache_write_addr);
            fl_data.push_back(icache_write_data);
        end
        // advance model to post-edge state
        f_en = 1'b0;
        if (tg != 4'd0 && out_v[tg]) begin
            f_en = 1'b1; f_addr = out_addr[tg]; f_data = dt;
            out_v[tg] = 1'b0; out_n--;
        end
        if (iss && rsp != 4'd0) begin
            out_v[rsp] = 1'b1; out_addr[rsp] = e_addr; out_n++;
            if (PF && dem) begin
                if (dblk == 32'hFFFF_FFF8) w_act = 1'b0;
                else begin w_act = 1'b1; w_addr = dblk + 32'd8; w_left = PREFETCH_DEPTH; end
            end
        end
        if (wc && (skip || (iss && rsp != 4'd0))) begin
            w_left--;
            if (w_left == 0 || w_addr == 32'hFFFF_FFF8) w_act = 1'b0;
            else w_addr = w_addr + 32'd8;
        end
        @(posedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 4'd0, 4'd0, 64'h0);
    endtask

    task automatic clear_logs();
        ld_log.delete(); fl_addr.delete(); fl_data.delete();
        cmd_cnt = 0; cmd_at_4000 = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        miss_valid = 1'b1; miss_pc = $urandom; Imem2proc_response = 4'd1;
        Imem2proc_tag = 4'd0;
        #1;
        chk("rst_cmd", proc2Imem_command, 64'd0);
        chk("rst_addr", proc2Imem_addr, 64'd0);
        chk("rst_probe", prefetch_pc_check, 64'd0);
        chk("rst_wr_en", icache_write_enable, 64'd0);
        chk("rst_wr_addr", icache_write_addr, 64'd0);
        chk("rst_wr_data", icache_write_data, 64'd0);
        chk("rst_busy", busy, 64'd0);
        model_clear();
        @(negedge clock);
        reset_n = 1'b1; miss_valid = 1'b0; Imem2proc_response = 4'd0;
    endtask

    initial begin
        model_clear();
        do_reset();

        // single demand miss, tag returns 5 cycles later
        clear_logs();
        cycle(1'b1, 32'h1004, 4'd3, 4'd0, 64'h0);
        idle(4);
        cycle(1'b0, 32'h0, 4'd0, 4'd3, 64'hAAAA_BBBB_CCCC_DDDD);
        idle(2);
        chk("t1_loads", ld_log.size(), 64'd1);
        if (ld_log.size() > 0) chk("t1_ld_addr", ld_log[0], 64'h1000);
        chk("t1_fills", fl_addr.size(), 64'd1);
        if (fl_addr.size() > 0) begin
            chk("t1_fill_addr", fl_addr[0], 64'h1000);
            chk("t1_fill_data", fl_data[0], 64'hAAAA_BBBB_CCCC_DDDD);
        end

        if (PF) begin
            // walk with a resident block in the middle
            do_reset();
            clear_logs();
            res_addr = 32'h2010;
            cycle(1'b1, 32'h2000, nf(), 4'd0, 64'h0);
            for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, nf(), 4'd0, 64'h0);
            res_addr = 32'hFFFF_FFFF;
            chk("t2_loads", ld_log.size(), 64'd4);
            if (ld_log.size() == 4) begin
                chk("t2_ld0", ld_log[0], 64'h2000);
                chk("t2_ld1", ld_log[1], 64'h2008);
                chk("t2_ld2", ld_log[2], 64'h2018);
                chk("t2_ld3", ld_log[3], 64'h2020);
            end
        end

        // MSHR full: further miss waits, issues the cycle after the free
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h3000 + 32'(i) * 32'h100, nf(), 4'd0, 64'h0);
        clear_logs();
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h3800, nf(), 4'd0, 64'h0);
        chk("t3_full_idle", cmd_cnt, 64'd0);
        cycle(1'b1, 32'h3800, nf(), 4'd1, 64'h1234);
        chk("t3_free_cycle", cmd_cnt, 64'd0);
        cycle(1'b1, 32'h3800, nf(), 4'd0, 64'h0);
        chk("t3_after_free", ld_log.size(), 64'd1);
        if (ld_log.size() > 0) chk("t3_ld_addr", ld_log[0], 64'h3800);

        // rejected responses then grant with tag 5
        do_reset();
        clear_logs();
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h4000, 4'd0, 4'd0, 64'h0);
        cycle(1'b1, 32'h4000, 4'd5, 4'd0, 64'h0);
        idle(1);
        cycle(1'b0, 32'h0, 4'd0, 4'd6, 64'h6666);
        cycle(1'b0, 32'h0, 4'd0, 4'd5, 64'h5555_0000_5555);
        idle(1);
        chk("t4_presented", cmd_at_4000, 64'd4);
        chk("t4_loads", ld_log.size(), 64'd1);
        chk("t4_fills", fl_addr.size(), 64'd1);
        if (fl_addr.size() > 0) chk("t4_fill_addr", fl_addr[0], 64'h4000);

        // reset with 2 loads outstanding; late tags are dropped
        do_reset();
        cycle(1'b1, 32'h5000, 4'd1, 4'd0, 64'h0);
        cycle(1'b1, 32'h6000, 4'd2, 4'd0, 64'h0);
        chk("t5_busy_before", busy, 64'd1);
        do_reset();
        clear_logs();
        cycle(1'b0, 32'h0, 4'd0, 4'd1, 64'h11);
        cycle(1'b0, 32'h0, 4'd0, 4'd2, 64'h22);
        idle(1);
        chk("t5_fills", fl_addr.size(), 64'd0);
        chk("t5_busy", busy, 64'd0);

        if (PF) begin
            // walk stops at the top of memory
            do_reset();
            clear_logs();
            cycle(1'b1, 32'hFFFF_FFF0, nf(), 4'd0, 64'h0);
            for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, nf(), 4'd0, 64'h0);
            chk("t6_loads", ld_log.size(), 64'd2);
            if (ld_log.size() == 2) begin
                chk("t6_ld0", ld_log[0], 64'hFFFF_FFF0);
                chk("t6_ld1", ld_log[1], 64'hFFFF_FFF8);
            end
        end

        // randomized traffic against the model
        do_reset();
        rnd_res = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            logic        mv;
            logic [31:0] pc;
            logic [3:0]  rsp, tg;
            int          r;
            mv = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) pc = 32'hFFFF_FF00 | ($urandom & 32'hFF);
            else                            pc = 32'h0000_8000 | ($urandom & 32'h1FF);
            rsp = ($urandom_range(0, 9) < 7) ? rf() : 4'd0;
            r = $urandom_range(0, 9);
            if (r < 4)       tg = ro();
            else if (r == 4) tg = 4'($urandom);
            else             tg = 4'd0;
            cycle(mv, pc, rsp, tg, {$urandom, $urandom});
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
